code_window_tx: RTL and testbench



---
 rtl/code_tx_pkg.sv | 14 +
 rtl/code_window_tx_if.sv | 21 ++
 rtl/code_window_sreg.sv | 38 +++
 rtl/code_window_tx.sv | 130 +++++++++++++
 tb/tb_code_window_tx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/code_tx_pkg.sv
// Shared types and constants for the code window transmitter.
package code_tx_pkg;

    localparam int WIN_W = 3;
    localparam logic [12:0] BARKER13 = 13'b1111100110101;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_e;

endpackage

// File: rtl/code_window_tx_if.sv
// Valid/ready window stream from the transmitter to the correlator.
interface code_window_tx_if;
    import code_tx_pkg::*;

    logic [WIN_W-1:0] window_out;
    logic             valid_out;
    logic             ready_in;

    modport master (
        output window_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  window_out,
        input  valid_out,
        output ready_in
    );

endinterface

// File: rtl/code_window_sreg.sv
// Loadable left shift register holding the code; exposes its top window.
module code_window_sreg
    import code_tx_pkg::*;
#(
    parameter int                  CODE_LEN = 13,
    parameter logic [CODE_LEN-1:0] CODE     = BARKER13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             inv_i,
    input  logic             shift_i,
    output logic [WIN_W-1:0] top_o
);

    logic [CODE_LEN-1:0] sreg_q;
    logic [CODE_LEN-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = inv_i ? ~CODE : CODE;
        end else if (shift_i) begin
            sreg_d = {sreg_q[CODE_LEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign top_o = sreg_q[CODE_LEN-1 -: WIN_W];

endmodule

// File: rtl/code_window_tx.sv
// Code window transmitter: bursts of sliding 3-bit code windows.
// Option: CODE_TX_ALT_POLARITY_EN inverts every odd-indexed burst.
module code_window_tx
    import code_tx_pkg::*;
#(
    parameter int                  CODE_LEN   = 13,
    parameter logic [CODE_LEN-1:0] CODE       = BARKER13,
    parameter int                  GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        burst_len,
    code_window_tx_if.master  tx,
    output logic              busy,
    output logic              done
);

    localparam int WCW = $clog2(CODE_LEN);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] LAST_WIN = WCW'(CODE_LEN - 3);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

    state_e         state_q, state_d;
    logic [WCW-1:0] win_q, win_d;
    logic [7:0]     burst_q, burst_d;
    logic [GCW-1:0] gap_q, gap_d;
    logic           load, load_inv, shift;
    logic [WIN_W-1:0] top;
    logic           pol_q, pol_d;

    code_window_sreg #(
        .CODE_LEN (CODE_LEN),
        .CODE     (CODE)
    ) u_sreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .inv_i   (load_inv),
        .shift_i (shift),
        .top_o   (top)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            pol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            pol_q   <= pol_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        burst_d  = burst_q;
        gap_d    = gap_q;
        pol_d    = pol_q;
        load     = 1'b0;
        load_inv = 1'b0;
        shift    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && burst_len == 8'd0) begin
                    state_d = DONE;
                end else if (start) begin
                    state_d = SEND;
                    burst_d = burst_len;
                    win_d   = '0;
                    pol_d   = 1'b0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (tx.ready_in) begin
                    shift = 1'b1;
                    win_d = win_q + 1'b1;
                    if (win_q == LAST_WIN) begin
                        win_d   = '0;
                        burst_d = burst_q - 8'd1;
`ifdef CODE_TX_ALT_POLARITY_EN
                        pol_d   = ~pol_q;
`endif
                        if (burst_q == 8'd1) begin
                            state_d = DONE;
                        end else if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end else begin
                            // back-to-back bursts: reload instead of shifting
                            load     = 1'b1;
                            load_inv = pol_d;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d  = SEND;
                    gap_d    = '0;
                    load     = 1'b1;
                    load_inv = pol_q;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx.valid_out  = (state_q == SEND);
        tx.window_out = tx.valid_out ? top : '0;
        busy          = (state_q == SEND) || (state_q == GAP);
        done          = (state_q == DONE);
    end

endmodule

// File: tb/tb_code_window_tx.sv
// Scoreboard bench for code_window_tx (Barker-13, gap 4).
module tb_code_window_tx;
    import code_tx_pkg::*;

    localparam int CL = 13;
    localparam int G  = 4;
    localparam logic [CL-1:0] CODE = BARKER13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       busy, done;

    code_window_tx_if tx_if ();

    code_window_tx #(
        .CODE_LEN   (CL),
        .CODE       (CODE),
        .GAP_CYCLES (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .tx        (tx_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [2:0] sb_q[$];
    int cyc = 0;
    int busy_tot = 0;
    int done_cnt = 0;
    int hs_cyc = 0;
    bit hs_seen = 0;
    bit prev_stall = 0;
    logic [2:0] prev_win = '0;

    task automatic push_model(input int nb);
        logic [CL-1:0] c;
        for (int b = 0; b < nb; b++) begin
            c = CODE;
`ifdef CODE_TX_ALT_POLARITY_EN
            if (b % 2 == 1) c = ~CODE;
`endif
            for (int w = 0; w < CL - 2; w++) begin
                sb_q.push_back(c[CL-1-w -: 3]);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
            hs_seen    = 0;
        end else begin
            if (busy) busy_tot++;
            if (prev_stall) begin
                chk("hold_valid", tx_if.valid_out, 1);
                chk("hold_win", tx_if.window_out, prev_win);
            end
            if (!tx_if.valid_out) begin
                chk("idle_win", tx_if.window_out, 0);
            end else if (tx_if.ready_in) begin
                if (sb_q.size() == 0) chk("extra_win", 1, 0);
                else chk("win", tx_if.window_out, sb_q.pop_front());
                hs_cyc  = cyc;
                hs_seen = 1;
            end
            prev_stall = tx_if.valid_out && !tx_if.ready_in;
            prev_win   = tx_if.window_out;
            if (done) begin
                done_cnt++;
                chk("done_busy", busy, 0);
                chk("sb_empty", sb_q.size(), 0);
                if (hs_seen) chk("done_lat", cyc - hs_cyc, 1);
                hs_seen = 0;
            end
        end
    end

    task automatic kick(input int len);
        @(posedge clk); #1;
        start     = 1'b1;
        burst_len = 8'(len);
        push_model(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("done_seen", done_cnt - d0, 1);
    endtask

    int b0, d0, n;

    initial begin
        tx_if.ready_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", tx_if.valid_out, 0);
        chk("rst_win", tx_if.window_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single burst, continuous ready
        b0 = busy_tot;
        kick(1);
        wait_done(100);
        chk("busy_1", busy_tot - b0, CL - 2);

        // two bursts with gap
        b0 = busy_tot;
        kick(2);
        wait_done(200);
        chk("busy_2", busy_tot - b0, 2 * (CL - 2) + G);

        // stall on window index 3
        b0 = busy_tot;
        kick(1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        tx_if.ready_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_win", tx_if.window_out, 3'b110);
            chk("stall_valid", tx_if.valid_out, 1);
            @(posedge clk); #1;
        end
        tx_if.ready_in = 1'b1;
        wait_done(100);
        chk("busy_stall", busy_tot - b0, CL - 2 + 3);

        // zero-length request
        d0 = done_cnt;
        kick(0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_valid", tx_if.valid_out, 0);
        @(posedge clk); #1;
        chk("zero_cnt", done_cnt - d0, 1);

        // start while busy is ignored
        b0 = busy_tot;
        kick(1);
        @(posedge clk); #1;
        start     = 1'b1;
        burst_len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        chk("busy_ign", busy_tot - b0, CL - 2);

        // reset mid-burst at window index 5
        d0 = done_cnt;
        kick(1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("abort_valid", tx_if.valid_out, 0);
        chk("abort_win", tx_if.window_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_nodone", done_cnt - d0, 0);
        kick(1);
        wait_done(100);

        // random backpressure over three bursts
        kick(3);
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1;
            tx_if.ready_in = 1'($urandom % 2);
            n++;
        end
        chk("rand_done", done_cnt - d0, 1);
        tx_if.ready_in = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
